// File: rtl/ex_pkg.sv
// ex_pkg: shared types for the execute stage.
// The multiplier FSM enum is only used when EX_MUL_EN is defined.
package ex_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_MUL = 3'b111;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_ZERO = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic [1:0]  result_src;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } ex_mem_t;

endpackage

// File: rtl/ex_if.sv
// ex_if: E-stage bundle in, EX/MEM bundle and redirect/stall out.
// master = ID/EX + hazard side, slave = ex_stage.
interface ex_if;
  logic        RegWriteE;
  logic        MemWriteE;
  logic        ALUSrcE;
  logic        BranchE;
  logic        JumpE;
  logic [2:0]  ALUControlE;
  logic [1:0]  ResultSrcE;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] ImmExtE;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;
  logic [4:0]  RdE;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        MulStallE;
  logic        RegWriteM;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;
  logic [4:0]  RdM;

  modport master (
    output RegWriteE, MemWriteE, ALUSrcE,
    output BranchE, JumpE, ALUControlE,
    output ResultSrcE, RD1E, RD2E, ImmExtE,
    output PCE, PCPlus4E, RdE,
    output ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE, MulStallE,
    input  RegWriteM, MemWriteM, ResultSrcM,
    input  ALUResultM, WriteDataM, PCPlus4M,
    input  RdM
  );

  modport slave (
    input  RegWriteE, MemWriteE, ALUSrcE,
    input  BranchE, JumpE, ALUControlE,
    input  ResultSrcE, RD1E, RD2E, ImmExtE,
    input  PCE, PCPlus4E, RdE,
    input  ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE, MulStallE,
    output RegWriteM, MemWriteM, ResultSrcM,
    output ALUResultM, WriteDataM, PCPlus4M,
    output RdM
  );

endinterface

// File: rtl/ex_mul_iter.sv
// mul_iter: shift-add multiplier, MUL_RADIX_BITS bits per BUSY cycle.
// Only compiled when EX_MUL_EN is defined.
`ifdef EX_MUL_EN
module mul_iter
  import ex_pkg::*;
#(
  parameter int MUL_RADIX_BITS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] prod_o
);

  localparam int STEPS = 32 / MUL_RADIX_BITS;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

  mul_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] part;

  always_comb begin
    part = '0;
    for (int i = 0; i < MUL_RADIX_BITS; i++) begin
      if (b_q[i]) part = part + (a_q << i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = BUSY;
          cnt_d   = '0;
          a_d     = a_i;
          b_d     = b_i;
          acc_d   = '0;
        end
      end
      BUSY: begin
        acc_d = acc_q + part;
        a_d   = a_q << MUL_RADIX_BITS;
        b_d   = b_q >> MUL_RADIX_BITS;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  assign busy_o = (state_q == BUSY);
  assign done_o = (state_q == DONE);
  assign prod_o = acc_q;

endmodule
`endif

// File: rtl/ex_stage.sv
// ex_stage: RV32 execute - forwarding, ALU, branch resolve, EX/MEM reg.
// Define EX_MUL_EN to build the iterative multiplier (ALU op 111).
module ex_stage
  import ex_pkg::*;
#(
  parameter int MUL_RADIX_BITS = 2
) (
  input  logic clk,
  input  logic reset,
  ex_if.slave  ex
);

  if ((MUL_RADIX_BITS < 1) || (32 % MUL_RADIX_BITS != 0)) begin : g_chk
    $error("MUL_RADIX_BITS must divide 32");
  end

  ex_mem_t     ex_mem_q, ex_mem_d;
  ex_mem_t     e_bundle;
  logic [31:0] src_a, src_b, wdata, alu_res;

  always_comb begin
    unique case (ex.ForwardAE)
      FWD_RF:  src_a = ex.RD1E;
      FWD_WB:  src_a = ex.ResultW;
      FWD_MEM: src_a = ex_mem_q.alu_result;
      default: src_a = '0;
    endcase
    unique case (ex.ForwardBE)
      FWD_RF:  wdata = ex.RD2E;
      FWD_WB:  wdata = ex.ResultW;
      FWD_MEM: wdata = ex_mem_q.alu_result;
      default: wdata = '0;
    endcase
    src_b = ex.ALUSrcE ? ex.ImmExtE : wdata;
  end

  // mul is never produced here; its result comes from the EX/MEM load
  always_comb begin
    alu_res = '0;
    unique case (ex.ALUControlE)
      ALU_ADD: alu_res = src_a + src_b;
      ALU_SUB: alu_res = src_a - src_b;
      ALU_AND: alu_res = src_a & src_b;
      ALU_OR:  alu_res = src_a | src_b;
      ALU_SLT: alu_res = {31'b0, $signed(src_a) < $signed(src_b)};
      default: alu_res = '0;
    endcase
  end

  assign ex.PCTargetE = ex.PCE + ex.ImmExtE;
  assign ex.PCSrcE = (ex.BranchE & (alu_res == '0)) | ex.JumpE;

  always_comb begin
    e_bundle.reg_write  = ex.RegWriteE;
    e_bundle.mem_write  = ex.MemWriteE;
    e_bundle.result_src = ex.ResultSrcE;
    e_bundle.alu_result = alu_res;
    e_bundle.write_data = wdata;
    e_bundle.pc_plus4   = ex.PCPlus4E;
    e_bundle.rd         = ex.RdE;
  end

`ifdef EX_MUL_EN
  logic        mul_start, mul_busy, mul_done;
  logic [31:0] mul_prod;
  logic        mul_rw_q, mul_rw_d;
  logic [1:0]  mul_rs_q, mul_rs_d;
  logic [4:0]  mul_rd_q, mul_rd_d;

  assign mul_start = ~mul_busy & ~mul_done &
                     (ex.ALUControlE == ALU_MUL);

  mul_iter #(
    .MUL_RADIX_BITS(MUL_RADIX_BITS)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start_i(mul_start),
    .a_i    (src_a),
    .b_i    (src_b),
    .busy_o (mul_busy),
    .done_o (mul_done),
    .prod_o (mul_prod)
  );

  always_comb begin
    mul_rw_d = mul_rw_q;
    mul_rs_d = mul_rs_q;
    mul_rd_d = mul_rd_q;
    if (mul_start) begin
      mul_rw_d = ex.RegWriteE;
      mul_rs_d = ex.ResultSrcE;
      mul_rd_d = ex.RdE;
    end
  end

  always_comb begin
    ex_mem_d = e_bundle;
    if (mul_start | mul_busy) begin
      ex_mem_d = '0;
    end else if (mul_done) begin
      ex_mem_d            = '0;
      ex_mem_d.reg_write  = mul_rw_q;
      ex_mem_d.result_src = mul_rs_q;
      ex_mem_d.alu_result = mul_prod;
      ex_mem_d.rd         = mul_rd_q;
    end
  end

  assign ex.MulStallE = mul_start | mul_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_rw_q <= 1'b0;
      mul_rs_q <= '0;
      mul_rd_q <= '0;
    end else begin
      mul_rw_q <= mul_rw_d;
      mul_rs_q <= mul_rs_d;
      mul_rd_q <= mul_rd_d;
    end
  end
`else
  always_comb ex_mem_d = e_bundle;
  assign ex.MulStallE = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) ex_mem_q <= '0;
    else       ex_mem_q <= ex_mem_d;
  end

  assign ex.RegWriteM  = ex_mem_q.reg_write;
  assign ex.MemWriteM  = ex_mem_q.mem_write;
  assign ex.ResultSrcM = ex_mem_q.result_src;
  assign ex.ALUResultM = ex_mem_q.alu_result;
  assign ex.WriteDataM = ex_mem_q.write_data;
  assign ex.PCPlus4M   = ex_mem_q.pc_plus4;
  assign ex.RdM        = ex_mem_q.rd;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: random + directed stimulus, scoreboard on EX/MEM outputs.
// Multiply checks are built only when EX_MUL_EN is defined.
module tb_ex_stage;

  localparam int R = 2;
  localparam int N = 32 / R;

  typedef struct {
    bit        rw, mw, alusrc, br, jmp;
    bit [2:0]  op;
    bit [1:0]  rs, fa, fb;
    bit [31:0] rd1, rd2, imm, pc, pc4, resw;
    bit [4:0]  rd;
  } ein_t;

  typedef struct {
    logic        rw, mw;
    logic [1:0]  rs;
    logic [31:0] alu, wd, pc4;
    logic [4:0]  rd;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [31:0] m_alu = '0;

  ex_if bus ();

  ex_stage #(.MUL_RADIX_BITS(R)) dut (
    .clk  (clk),
    .reset(reset),
    .ex   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(bit [1:0] s, logic [31:0] rf,
                                      logic [31:0] w, logic [31:0] m);
    case (s)
      2'd0:    return rf;
      2'd1:    return w;
      2'd2:    return m;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] alu_ref(bit [2:0] op, logic [31:0] a,
                                          logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic ein_t rand_e();
    ein_t e;
    e.rw = 1'($urandom); e.mw = 1'($urandom);
    e.alusrc = 1'($urandom); e.br = 1'($urandom);
    e.jmp = ($urandom_range(0, 7) == 0);
`ifdef EX_MUL_EN
    e.op = 3'($urandom_range(0, 6));
`else
    e.op = 3'($urandom_range(0, 7));
`endif
    e.rs = 2'($urandom); e.fa = 2'($urandom); e.fb = 2'($urandom);
    e.rd1 = $urandom; e.rd2 = $urandom; e.imm = $urandom;
    e.pc = $urandom; e.pc4 = $urandom; e.resw = $urandom;
    e.rd = 5'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      e.op = 3'd1; e.fa = 2'd0; e.fb = 2'd0;
      e.alusrc = 1'b0; e.rd2 = e.rd1;
    end
    return e;
  endfunction

  function automatic ein_t bubble();
    ein_t e;
    e = rand_e();
    e.rw = 0; e.mw = 0; e.br = 0; e.jmp = 0; e.op = 3'd0;
    return e;
  endfunction

  task automatic drive(ein_t e);
    bus.RegWriteE = e.rw; bus.MemWriteE = e.mw;
    bus.ALUSrcE = e.alusrc; bus.BranchE = e.br; bus.JumpE = e.jmp;
    bus.ALUControlE = e.op; bus.ResultSrcE = e.rs;
    bus.RD1E = e.rd1; bus.RD2E = e.rd2; bus.ImmExtE = e.imm;
    bus.PCE = e.pc; bus.PCPlus4E = e.pc4; bus.RdE = e.rd;
    bus.ForwardAE = e.fa; bus.ForwardBE = e.fb; bus.ResultW = e.resw;
  endtask

  task automatic push(exp_t x);
    q.push_back(x);
    m_alu = x.alu;
  endtask

  task automatic step(ein_t e, bit rst);
    exp_t x;
    logic [31:0] a, wd, b, r;
    logic pcs;
    @(negedge clk);
    drive(e);
    reset = rst;
    a = fwd(e.fa, e.rd1, e.resw, m_alu);
    wd = fwd(e.fb, e.rd2, e.resw, m_alu);
    b = e.alusrc ? e.imm : wd;
    r = alu_ref(e.op, a, b);
    pcs = (e.br && (r == 32'd0)) || e.jmp;
    #1;
    chk("pcsrc", {31'b0, bus.PCSrcE}, {31'b0, pcs});
    chk("pctarget", bus.PCTargetE, e.pc + e.imm);
    chk("mulstall", {31'b0, bus.MulStallE}, 32'd0);
    if (rst) x = '{0, 0, 0, 0, 0, 0, 0};
    else x = '{e.rw, e.mw, e.rs, r, wd, e.pc4, e.rd};
    push(x);
  endtask

`ifdef EX_MUL_EN
  task automatic do_mul(ein_t e, int abort_at, output int stalls);
    logic [31:0] a, b, prod;
    @(negedge clk);
    drive(e);
    reset = 1'b0;
    a = fwd(e.fa, e.rd1, e.resw, m_alu);
    b = e.alusrc ? e.imm : fwd(e.fb, e.rd2, e.resw, m_alu);
    prod = a * b;
    #1;
    stalls = int'(bus.MulStallE);
    chk("mul_pcsrc", {31'b0, bus.PCSrcE}, 32'd0);
    push('{0, 0, 0, 0, 0, 0, 0});
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      drive(bubble());
      reset = (i == abort_at);
      #1;
      stalls += int'(bus.MulStallE);
      push('{0, 0, 0, 0, 0, 0, 0});
      if (i == abort_at) return;
    end
    @(negedge clk);
    drive(bubble());
    reset = 1'b0;
    #1;
    chk("stall_done", {31'b0, bus.MulStallE}, 32'd0);
    push('{e.rw, 0, e.rs, prod, 0, 0, e.rd});
  endtask
`endif

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("RegWriteM", {31'b0, bus.RegWriteM}, {31'b0, x.rw});
        chk("MemWriteM", {31'b0, bus.MemWriteM}, {31'b0, x.mw});
        chk("ResultSrcM", {30'b0, bus.ResultSrcM}, {30'b0, x.rs});
        chk("ALUResultM", bus.ALUResultM, x.alu);
        chk("WriteDataM", bus.WriteDataM, x.wd);
        chk("PCPlus4M", bus.PCPlus4M, x.pc4);
        chk("RdM", {27'b0, bus.RdM}, {27'b0, x.rd});
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    ein_t e, z;
    int s;
    z = '{default: 0};
    drive(z);
    step(z, 1);
    step(z, 1);

    e = z; e.op = 3'd0; e.rd1 = 5; e.rd2 = 7; e.rw = 1; e.rd = 5'd3;
    step(e, 0);
    e = z; e.op = 3'd5; e.rd1 = 32'hFFFF_FFFF; e.rd2 = 1; e.rd = 5'd4;
    step(e, 0);
    e = z; e.op = 3'd1; e.rd1 = 3; e.rd2 = 5; e.rw = 1; e.rd = 5'd5;
    step(e, 0);
    e = z; e.op = 3'd1; e.br = 1; e.rd1 = 9; e.rd2 = 9;
    e.pc = 32'h100; e.imm = 32'h20;
    step(e, 0);
    e = z; e.op = 3'd0; e.rd1 = 1; e.rd2 = 1;
    step(e, 0);
    e = z; e.op = 3'd0; e.fa = 2'd1; e.resw = 40; e.fb = 2'd2; e.rd = 5'd6;
    step(e, 0);

    for (int i = 0; i < 200; i++) step(rand_e(), 0);

`ifdef EX_MUL_EN
    e = z; e.op = 3'd7; e.rd1 = 32'h10000; e.rd2 = 32'h10003;
    e.rw = 1; e.rs = 2'd1; e.rd = 5'd9;
    do_mul(e, -1, s);
    chk("mul_stall_cycles", s, 1 + N);
    e = z; e.op = 3'd0; e.fa = 2'd2; e.rd2 = 1; e.rw = 1; e.rd = 5'd10;
    step(e, 0);
    for (int k = 0; k < 4; k++) begin
      e = rand_e(); e.op = 3'd7; e.br = 0; e.jmp = 0;
      do_mul(e, -1, s);
      chk("mul_stall_cycles", s, 1 + N);
      step(rand_e(), 0);
    end
    e = z; e.op = 3'd7; e.rd1 = 6; e.rd2 = 7; e.rw = 1; e.rd = 5'd11;
    do_mul(e, 3, s);
    chk("abort_stall_cycles", s, 5);
`else
    e = z; e.op = 3'd7; e.rd1 = 6; e.rd2 = 7; e.rw = 1; e.rd = 5'd11;
    step(e, 0);
    step(bubble(), 1);
`endif
    e = z; e.op = 3'd0; e.rd1 = 20; e.rd2 = 22; e.rw = 1; e.rd = 5'd12;
    step(e, 0);
    for (int i = 0; i < 20; i++) step(rand_e(), 0);

    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
